collision_score: RTL and testbench

- Consumes the positions of all obstacles (each obstacle's right-edge x and upper-tile height) and the player's y position.
- Detects player/obstacle and player/floor collisions, counts obstacles passed as a 3-digit BCD score, and tracks a high score.
- Runs the game state machine (idle/play/hit/over). Its freeze and game_over outputs gate player motion and the text overlay downstream.

---
 rtl/collision_score_if.sv | 27 ++
 rtl/collision_score.sv | 185 ++++++++++++++++++
 tb/tb_collision_score.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/collision_score_if.sv
// Bus between the game-logic block and its environment: frame/button
// events, player and obstacle positions in, game status and scores out.
interface collision_score_if #(
  parameter int N_OBS = 4
);
  logic                  frame_tick;
  logic                  start;
  logic [9:0]            p_y;
  logic [10*N_OBS-1:0]   obs_x;
  logic [10*N_OBS-1:0]   obs_h;
  logic                  game_active;
  logic                  freeze;
  logic                  game_over;
  logic                  hit_pulse;
  logic [11:0]           score_bcd;
  logic [11:0]           hi_bcd;

  modport master (
    output frame_tick, start, p_y, obs_x, obs_h,
    input  game_active, freeze, game_over, hit_pulse, score_bcd, hi_bcd
  );

  modport slave (
    input  frame_tick, start, p_y, obs_x, obs_h,
    output game_active, freeze, game_over, hit_pulse, score_bcd, hi_bcd
  );
endinterface

// File: rtl/collision_score.sv
// Collision detection, BCD scoring with high score, and the
// idle/play/hit/over game state machine. All outputs are registered.
module collision_score #(
  parameter int N_OBS      = 4,
  parameter int P_X        = 100,
  parameter int P_W        = 20,
  parameter int P_H        = 20,
  parameter int T_W        = 29,
  parameter int S_Z        = 120,
  parameter int SCR_H      = 480,
  parameter int HOLD_TICKS = 60
) (
  input  logic              clk,
  input  logic              reset,
  collision_score_if.slave  bus
);
  localparam int CW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t               state_r, state_next_s;
  logic [CW-1:0]        hold_r, hold_next_s;
  logic [11:0]          score_r, score_next_s, pass_sum_s;
  logic [11:0]          hi_r, hi_next_s;
  logic [10*N_OBS-1:0]  prev_x_r;
  logic [N_OBS-1:0]     pass_s;
  logic                 any_hit_s;
  logic                 game_active_r, freeze_r, game_over_r, hit_pulse_r;
  logic                 ga_next_s, fr_next_s, go_next_s, hp_next_s;

  // BCD increment that sticks at 999.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else if (v[7:4] != 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[7:0]  = 8'h00;
      r[11:8] = v[11:8] + 4'd1;
    end
    return r;
  endfunction

  // Player/obstacle overlap test, done at 11 bits so sums cannot wrap.
  function automatic logic obs_hit(input logic [9:0] ox, input logic [9:0] oh,
                                   input logic [9:0] py);
    logic [10:0] x11, h11, y11;
    logic        xov, yhit;
    x11  = {1'b0, ox};
    h11  = {1'b0, oh};
    y11  = {1'b0, py};
    xov  = (11'(P_X) <= x11) && (11'(P_X + P_W - 1 + T_W - 1) >= x11);
    yhit = (y11 < h11) || ((y11 + 11'(P_H - 1)) >= (h11 + 11'(S_Z - 1)));
    return xov && yhit;
  endfunction

  // Hit and pass detection across all obstacles plus the floor.
  always_comb begin
    any_hit_s = ({1'b0, bus.p_y} + 11'(P_H - 1)) >= 11'(SCR_H - 1);
    pass_s    = '0;
    for (int i = 0; i < N_OBS; i++) begin
      if (obs_hit(bus.obs_x[10*i +: 10], bus.obs_h[10*i +: 10], bus.p_y)) begin
        any_hit_s = 1'b1;
      end else begin
        any_hit_s = any_hit_s;
      end
      pass_s[i] = (prev_x_r[10*i +: 10] >= 10'(P_X)) &&
                  (bus.obs_x[10*i +: 10] < 10'(P_X));
    end
  end

  // Score after adding one per passing obstacle, saturating.
  always_comb begin
    pass_sum_s = score_r;
    for (int i = 0; i < N_OBS; i++) begin
      if (pass_s[i]) begin
        pass_sum_s = bcd_inc_sat(pass_sum_s);
      end else begin
        pass_sum_s = pass_sum_s;
      end
    end
  end

  // Next state, hold counter, score and high score.
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_r;
    score_next_s = score_r;
    hi_next_s    = hi_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_next_s = S_PLAY;
          score_next_s = 12'h000;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_PLAY: begin
        if (any_hit_s) begin
          state_next_s = S_HIT;
          hold_next_s  = '0;
          if (score_r > hi_r) begin
            hi_next_s = score_r;
          end else begin
            hi_next_s = hi_r;
          end
        end else begin
          score_next_s = pass_sum_s;
        end
      end
      S_HIT: begin
        if (bus.frame_tick) begin
          if (hold_r == CW'(HOLD_TICKS - 1)) begin
            state_next_s = S_OVER;
            hold_next_s  = '0;
          end else begin
            hold_next_s = hold_r + CW'(1);
          end
        end else begin
          hold_next_s = hold_r;
        end
      end
      S_OVER: begin
        if (bus.start) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_OVER;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Output values decoded from the upcoming state.
  always_comb begin
    ga_next_s = (state_next_s == S_PLAY);
    fr_next_s = (state_next_s == S_HIT) || (state_next_s == S_OVER);
    go_next_s = (state_next_s == S_OVER);
    hp_next_s = (state_r == S_PLAY) && (state_next_s == S_HIT);
  end

  // State, counters, scores and registered outputs.
  always_ff @(posedge clk) begin
    prev_x_r <= bus.obs_x;
    if (reset) begin
      state_r       <= S_IDLE;
      hold_r        <= '0;
      score_r       <= 12'h000;
      hi_r          <= 12'h000;
      game_active_r <= 1'b0;
      freeze_r      <= 1'b0;
      game_over_r   <= 1'b0;
      hit_pulse_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      hold_r        <= hold_next_s;
      score_r       <= score_next_s;
      hi_r          <= hi_next_s;
      game_active_r <= ga_next_s;
      freeze_r      <= fr_next_s;
      game_over_r   <= go_next_s;
      hit_pulse_r   <= hp_next_s;
    end
  end

  assign bus.game_active = game_active_r;
  assign bus.freeze      = freeze_r;
  assign bus.game_over   = game_over_r;
  assign bus.hit_pulse   = hit_pulse_r;
  assign bus.score_bcd   = score_r;
  assign bus.hi_bcd      = hi_r;
endmodule

// File: tb/tb_collision_score.sv
// Directed table-driven bench for collision_score plus hand-written
// sequences for the hit hold time and score saturation.
module tb_collision_score;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_score_if #(.N_OBS(N)) bus ();
  collision_score #(.N_OBS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst, st, ft;
    logic [9:0]  py;
    logic [39:0] ox, oh;
    logic        ga, fr, go, hp;
    logic [11:0] sc, hi;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  localparam logic [39:0] PARK = {4{10'd670}};
  localparam logic [39:0] H100 = {4{10'd100}};

  function automatic logic [39:0] xs(input int a3, input int a2, input int a1, input int a0);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic add(input logic rst, input logic st, input logic ft, input int py,
                     input logic [39:0] ox, input logic [39:0] oh,
                     input logic ga, input logic fr, input logic go, input logic hp,
                     input logic [11:0] sc, input logic [11:0] hi);
    tv[nv] = '{rst, st, ft, 10'(py), ox, oh, ga, fr, go, hp, sc, hi};
    nv++;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic ft, input logic [9:0] py,
                       input logic [39:0] ox, input logic [39:0] oh);
    reset          = rst;
    bus.start      = st;
    bus.frame_tick = ft;
    bus.p_y        = py;
    bus.obs_x      = ox;
    bus.obs_h      = oh;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ga, input logic fr, input logic go,
                            input logic hp, input logic [11:0] sc, input logic [11:0] hi);
    chk({tag, "/game_active"}, {11'd0, bus.game_active}, {11'd0, ga});
    chk({tag, "/freeze"},      {11'd0, bus.freeze},      {11'd0, fr});
    chk({tag, "/game_over"},   {11'd0, bus.game_over},   {11'd0, go});
    chk({tag, "/hit_pulse"},   {11'd0, bus.hit_pulse},   {11'd0, hp});
    chk({tag, "/score"},       bus.score_bcd,            sc);
    chk({tag, "/hi"},          bus.hi_bcd,               hi);
  endtask

  task automatic run(input int lo, input int hi_idx);
    for (int k = lo; k < hi_idx; k++) begin
      drive(tv[k].rst, tv[k].st, tv[k].ft, tv[k].py, tv[k].ox, tv[k].oh);
      expect_out($sformatf("vec%0d", k), tv[k].ga, tv[k].fr, tv[k].go, tv[k].hp,
                 tv[k].sc, tv[k].hi);
    end
  endtask

  // From HIT: 59 ticks keep HIT (start on one is ignored), the 60th gives OVER.
  task automatic hold_to_over(input string tag, input logic [11:0] sc, input logic [11:0] hi);
    for (int t = 1; t < 60; t++) begin
      drive(1'b0, (t == 30), 1'b1, 10'd150, PARK, H100);
    end
    expect_out({tag, "_t59"}, 1'b0, 1'b1, 1'b0, 1'b0, sc, hi);
    drive(1'b0, 1'b0, 1'b1, 10'd150, PARK, H100);
    expect_out({tag, "_t60"}, 1'b0, 1'b1, 1'b1, 1'b0, sc, hi);
  endtask

  int a_end, b_end;

  initial begin
    // Table A: reset, single pass, gap/x boundaries, multi-pass, BCD carry, hit+pass.
    add(1, 0, 0, 150, PARK, H100, 0, 0, 0, 0, 12'h000, 12'h000);
    add(1, 0, 0, 150, PARK, H100, 0, 0, 0, 0, 12'h000, 12'h000);
    add(0, 0, 0, 150, PARK, H100, 0, 0, 0, 0, 12'h000, 12'h000);
    add(0, 1, 0, 150, xs(670, 670, 670, 101), H100, 1, 0, 0, 0, 12'h000, 12'h000);
    add(0, 0, 0, 150, xs(670, 670, 670, 100), H100, 1, 0, 0, 0, 12'h000, 12'h000);
    add(0, 0, 0, 150, xs(670, 670, 670, 99),  H100, 1, 0, 0, 0, 12'h001, 12'h000);
    add(0, 0, 0, 99,  xs(670, 670, 670, 148), H100, 1, 0, 0, 0, 12'h001, 12'h000);
    add(0, 0, 0, 199, xs(670, 670, 670, 147), H100, 1, 0, 0, 0, 12'h001, 12'h000);
    add(0, 0, 0, 100, xs(670, 670, 670, 147), H100, 1, 0, 0, 0, 12'h001, 12'h000);
    add(0, 0, 0, 150, xs(670, 670, 100, 100), H100, 1, 0, 0, 0, 12'h001, 12'h000);
    add(0, 0, 0, 150, xs(670, 670, 99, 99),   H100, 1, 0, 0, 0, 12'h003, 12'h000);
    add(0, 0, 0, 150, xs(100, 100, 100, 100), H100, 1, 0, 0, 0, 12'h003, 12'h000);
    add(0, 0, 0, 150, xs(99, 99, 99, 99),     H100, 1, 0, 0, 0, 12'h007, 12'h000);
    add(0, 0, 0, 150, xs(99, 99, 100, 100),   H100, 1, 0, 0, 0, 12'h007, 12'h000);
    add(0, 0, 0, 150, xs(99, 99, 99, 99),     H100, 1, 0, 0, 0, 12'h009, 12'h000);
    add(0, 0, 0, 150, xs(99, 99, 99, 100),    H100, 1, 0, 0, 0, 12'h009, 12'h000);
    add(0, 0, 0, 150, xs(99, 99, 99, 99),     H100, 1, 0, 0, 0, 12'h010, 12'h000);
    add(0, 0, 0, 150, PARK, H100, 1, 0, 0, 0, 12'h010, 12'h000);
    add(0, 0, 0, 150, xs(670, 670, 100, 670), H100, 1, 0, 0, 0, 12'h010, 12'h000);
    add(0, 0, 0, 150, xs(670, 110, 99, 670), xs(100, 200, 100, 100),
        0, 1, 0, 1, 12'h010, 12'h010);
    add(0, 1, 0, 150, PARK, H100, 0, 1, 0, 0, 12'h010, 12'h010);
    add(0, 0, 0, 460, PARK, H100, 0, 1, 0, 0, 12'h010, 12'h010);
    a_end = nv;
    // Table B: restart from OVER, collisions ignored in IDLE, floor boundary.
    add(0, 1, 0, 150, PARK, H100, 0, 0, 0, 0, 12'h010, 12'h010);
    add(0, 0, 0, 460, PARK, H100, 0, 0, 0, 0, 12'h010, 12'h010);
    add(0, 1, 0, 460, PARK, H100, 1, 0, 0, 0, 12'h000, 12'h010);
    add(0, 0, 0, 459, PARK, H100, 1, 0, 0, 0, 12'h000, 12'h010);
    add(0, 0, 0, 460, PARK, H100, 0, 1, 0, 1, 12'h000, 12'h010);
    b_end = nv;

    run(0, a_end);
    hold_to_over("hold1", 12'h010, 12'h010);
    run(a_end, b_end);
    hold_to_over("hold2", 12'h000, 12'h010);

    // Back to PLAY with a fresh score.
    drive(1'b0, 1'b1, 1'b0, 10'd150, PARK, H100);
    expect_out("over_to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h010);
    drive(1'b0, 1'b1, 1'b0, 10'd150, PARK, H100);
    expect_out("idle_to_play", 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h010);

    // Climb to 998: 249 rounds of four passes, then one round of two.
    for (int r = 0; r < 249; r++) begin
      drive(1'b0, 1'b0, 1'b0, 10'd150, xs(100, 100, 100, 100), H100);
      drive(1'b0, 1'b0, 1'b0, 10'd150, xs(99, 99, 99, 99), H100);
    end
    drive(1'b0, 1'b0, 1'b0, 10'd150, xs(99, 99, 100, 100), H100);
    drive(1'b0, 1'b0, 1'b0, 10'd150, xs(99, 99, 99, 99), H100);
    expect_out("preload", 1'b1, 1'b0, 1'b0, 1'b0, 12'h998, 12'h010);

    // Three more passes: 999 and held there.
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 1'b0, 1'b0, 10'd150, xs(99, 99, 99, 100), H100);
      drive(1'b0, 1'b0, 1'b0, 10'd150, xs(99, 99, 99, 99), H100);
      expect_out($sformatf("sat%0d", r), 1'b1, 1'b0, 1'b0, 1'b0, 12'h999, 12'h010);
    end

    // Hit on the lower gap edge at the far x overlap edge.
    drive(1'b0, 1'b0, 1'b0, 10'd200, xs(99, 99, 99, 147), H100);
    expect_out("gap_edge_hit", 1'b0, 1'b1, 1'b0, 1'b1, 12'h999, 12'h999);
    hold_to_over("hold3", 12'h999, 12'h999);
    drive(1'b0, 1'b1, 1'b0, 10'd150, PARK, H100);
    expect_out("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 12'h999, 12'h999);
    drive(1'b0, 1'b1, 1'b0, 10'd150, PARK, H100);
    expect_out("play2", 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h999);

    // Reset in the middle of play clears everything.
    drive(1'b1, 1'b0, 1'b0, 10'd150, PARK, H100);
    expect_out("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    drive(1'b0, 1'b0, 1'b0, 10'd150, PARK, H100);
    expect_out("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
